// File: rtl/apsr_cond_unit_pkg.sv
// Shared types for the APSR/condition unit: NZCV flags, condition encodings,
// ITSTATE layout and the condition evaluation function.
package apsr_cond_unit_pkg;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_t;

   // ITSTATE[7:5] is the shared base condition; mask[4] supplies the
   // per-slot condition LSB and mask[3:0] tracks the remaining slots.
   typedef struct packed {
      logic [2:0] base_cond;
      logic [4:0] mask;
   } itstate_t;

   function automatic logic cond_eval(input cond_t cond, input alu_flags_t f);
      logic res;
      case (cond)
         COND_EQ: res = f.z;
         COND_NE: res = !f.z;
         COND_CS: res = f.c;
         COND_CC: res = !f.c;
         COND_MI: res = f.n;
         COND_PL: res = !f.n;
         COND_VS: res = f.v;
         COND_VC: res = !f.v;
         COND_HI: res = f.c & !f.z;
         COND_LS: res = !f.c | f.z;
         COND_GE: res = (f.n == f.v);
         COND_LT: res = (f.n != f.v);
         COND_GT: res = !f.z & (f.n == f.v);
         COND_LE: res = f.z | (f.n != f.v);
         default: res = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/apsr_cond_unit_cond_check.sv
// Combinational condition checker; shared with the branch unit.
module cond_check
   import apsr_cond_unit_pkg::*;
(
   input  cond_t      cond_i,
   input  alu_flags_t flags_i,
   output logic       pass_o
);

   assign pass_o = cond_eval(cond_i, flags_i);

endmodule

// File: rtl/apsr_cond_unit.sv
// Architectural NZCV register, condition-pass evaluation and IT-block
// state machine for the execute stage.
module apsr_cond_unit
   import apsr_cond_unit_pkg::*;
#(
   parameter logic [3:0] RESET_NZCV = 4'b0000
) (
   input  logic       clk,
   input  logic       rst,
   input  alu_flags_t flags_in,
   input  logic       flags_we,
   input  logic       instr_valid,
   input  logic [3:0] instr_cond,
   input  logic       it_start,
   input  logic [3:0] it_firstcond,
   input  logic [3:0] it_mask,
   output alu_flags_t nzcv_out,
   output logic       cond_pass,
   output logic       in_it_block,
   output logic       it_last,
   output logic [7:0] itstate_out
);

   alu_flags_t nzcv_q;
   itstate_t   itstate_q;
   itstate_t   itstate_d;
   logic       it_fields_ok;
   logic       active;
   cond_t      ec;

   assign active       = (itstate_q.mask[3:0] != 4'b0000);
   assign it_fields_ok = (it_mask != 4'b0000) && (it_firstcond != 4'hF);

   // An IT instruction (even one with bad fields) blocks the slot advance.
   always_comb begin
      itstate_d = itstate_q;
      if (it_start) begin
         if (it_fields_ok) begin
            itstate_d.base_cond = it_firstcond[3:1];
            itstate_d.mask      = {it_firstcond[0], it_mask};
         end
      end else if (active && instr_valid) begin
         if (itstate_q.mask[2:0] == 3'b000) begin
            itstate_d = '0;
         end else begin
            itstate_d.mask = {itstate_q.mask[3:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nzcv_q    <= alu_flags_t'(RESET_NZCV);
         itstate_q <= '0;
      end else begin
         if (flags_we) begin
            nzcv_q <= flags_in;
         end
         itstate_q <= itstate_d;
      end
   end

   assign ec = active ? cond_t'({itstate_q.base_cond, itstate_q.mask[4]})
                      : cond_t'(instr_cond);

   cond_check u_cond_check (
      .cond_i  (ec),
      .flags_i (nzcv_q),
      .pass_o  (cond_pass)
   );

   assign nzcv_out    = nzcv_q;
   assign in_it_block = active;
   assign it_last     = active && (itstate_q.mask[3:0] == 4'b1000);
   assign itstate_out = itstate_q;

endmodule

// File: tb/tb_apsr_cond_unit.sv
// Directed bench for apsr_cond_unit: flags register, condition table,
// IT-block sequencing, reload and reset priority.
module tb_apsr_cond_unit;
   import apsr_cond_unit_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   alu_flags_t flags_in;
   logic       flags_we;
   logic       instr_valid;
   logic [3:0] instr_cond;
   logic       it_start;
   logic [3:0] it_firstcond;
   logic [3:0] it_mask;
   alu_flags_t nzcv_out;
   logic       cond_pass;
   logic       in_it_block;
   logic       it_last;
   logic [7:0] itstate_out;

   int n_tests = 0;
   int n_fail  = 0;

   apsr_cond_unit #(.RESET_NZCV(4'b0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .flags_in     (flags_in),
      .flags_we     (flags_we),
      .instr_valid  (instr_valid),
      .instr_cond   (instr_cond),
      .it_start     (it_start),
      .it_firstcond (it_firstcond),
      .it_mask      (it_mask),
      .nzcv_out     (nzcv_out),
      .cond_pass    (cond_pass),
      .in_it_block  (in_it_block),
      .it_last      (it_last),
      .itstate_out  (itstate_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Advance one edge, then leave time for inputs to be changed and sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_flags(input logic [3:0] f);
      flags_in = alu_flags_t'(f);
      flags_we = 1'b1;
      tick();
      flags_we = 1'b0;
      #1;
   endtask

   task automatic start_it(input logic [3:0] fc, input logic [3:0] m);
      it_start     = 1'b1;
      it_firstcond = fc;
      it_mask      = m;
      tick();
      it_start = 1'b0;
      #1;
   endtask

   task automatic step_slot();
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      #1;
   endtask

   task automatic check_it(input string tag, input logic [7:0] st,
                           input logic pass, input logic last);
      check({tag, "_st"},   itstate_out, st);
      check({tag, "_pass"}, {7'd0, cond_pass}, {7'd0, pass});
      check({tag, "_last"}, {7'd0, it_last}, {7'd0, last});
      check({tag, "_in"},   {7'd0, in_it_block}, {7'd0, (st[3:0] != 4'h0)});
   endtask

   // Reference table: even/odd codes are a base predicate and its inverse.
   function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
   endfunction

   initial begin
      rst = 1'b1; flags_in = '0; flags_we = 1'b0; instr_valid = 1'b0;
      instr_cond = 4'h0; it_start = 1'b0; it_firstcond = 4'h0; it_mask = 4'h0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_nzcv",  {4'd0, nzcv_out}, 8'h00);
      check("rst_it",    itstate_out, 8'h00);
      check("rst_in",    {7'd0, in_it_block}, 8'h00);
      check("rst_last",  {7'd0, it_last}, 8'h00);
      check("rst_eq",    {7'd0, cond_pass}, 8'h00);
      instr_cond = 4'hE; #1;
      check("rst_al",    {7'd0, cond_pass}, 8'h01);

      // Flags become visible one edge after the write.
      flags_in = alu_flags_t'(4'b0100); flags_we = 1'b1; instr_cond = 4'h0; #1;
      check("nobypass_nzcv", {4'd0, nzcv_out}, 8'h00);
      check("nobypass_eq",   {7'd0, cond_pass}, 8'h00);
      tick(); flags_we = 1'b0; #1;
      check("wr_nzcv", {4'd0, nzcv_out}, 8'h04);
      check("wr_eq",   {7'd0, cond_pass}, 8'h01);
      instr_cond = 4'h1; #1;
      check("wr_ne",   {7'd0, cond_pass}, 8'h00);

      load_flags(4'b1001);
      instr_cond = 4'hA; #1; check("n1v1_ge", {7'd0, cond_pass}, 8'h01);
      instr_cond = 4'hB; #1; check("n1v1_lt", {7'd0, cond_pass}, 8'h00);
      instr_cond = 4'h8; #1; check("n1v1_hi", {7'd0, cond_pass}, 8'h00);
      instr_cond = 4'h9; #1; check("n1v1_ls", {7'd0, cond_pass}, 8'h01);
      load_flags(4'b1000);
      instr_cond = 4'hA; #1; check("n1v0_ge", {7'd0, cond_pass}, 8'h00);
      instr_cond = 4'hD; #1; check("n1v0_le", {7'd0, cond_pass}, 8'h01);
      load_flags(4'b0010);
      instr_cond = 4'h8; #1; check("c1z0_hi", {7'd0, cond_pass}, 8'h01);
      instr_cond = 4'hC; #1; check("c1z0_gt", {7'd0, cond_pass}, 8'h01);

      for (int f = 0; f < 16; f++) begin
         load_flags(4'(f));
         for (int c = 0; c < 16; c++) begin
            instr_cond = 4'(c);
            #1;
            check($sformatf("sweep_f%0h_c%0h", f, c), {7'd0, cond_pass},
                  {7'd0, ref_pass(4'(c), 4'(f))});
         end
      end

      // IT EQ with Z set; instr_cond must be ignored inside the block.
      load_flags(4'b0100);
      instr_cond = 4'h1;
      start_it(4'h0, 4'b1000);
      check_it("it1", 8'h08, 1'b1, 1'b1);
      step_slot();
      check_it("it1_end", 8'h00, 1'b0, 1'b0);

      // mask 0110: slots EQ, EQ, NE
      start_it(4'h0, 4'b0110);
      check_it("itte_s1", 8'h06, 1'b1, 1'b0);
      step_slot();
      check_it("itte_s2", 8'h0C, 1'b1, 1'b0);
      step_slot();
      check_it("itte_s3", 8'h18, 1'b0, 1'b1);
      step_slot();
      check_it("itte_end", 8'h00, 1'b0, 1'b0);

      // mask 1010: slots EQ, NE, EQ
      start_it(4'h0, 4'b1010);
      check_it("itet_s1", 8'h0A, 1'b1, 1'b0);
      step_slot();
      check_it("itet_s2", 8'h14, 1'b0, 1'b0);
      step_slot();
      check_it("itet_s3", 8'h08, 1'b1, 1'b1);
      step_slot();
      check_it("itet_end", 8'h00, 1'b0, 1'b0);

      start_it(4'h0, 4'b0000);
      check("bad_mask", itstate_out, 8'h00);
      start_it(4'hF, 4'b1000);
      check("bad_fc", itstate_out, 8'h00);
      step_slot();
      check("idle_valid", itstate_out, 8'h00);

      // Invalid IT mid-block also suppresses the advance.
      start_it(4'h0, 4'b0110);
      instr_valid = 1'b1; it_start = 1'b1; it_firstcond = 4'hF; it_mask = 4'h8;
      tick(); instr_valid = 1'b0; it_start = 1'b0; #1;
      check("bad_mid", itstate_out, 8'h06);

      // Reload mid-block with a coincident instr_valid: reload, no advance.
      step_slot();
      check("pre_reload", itstate_out, 8'h0C);
      instr_valid = 1'b1; it_start = 1'b1; it_firstcond = 4'hA; it_mask = 4'b0100;
      tick(); instr_valid = 1'b0; it_start = 1'b0; #1;
      check_it("reload", 8'hA4, 1'b1, 1'b0);

      // Flag write and slot advance on the same edge.
      instr_valid = 1'b1; flags_we = 1'b1; flags_in = alu_flags_t'(4'b1000);
      tick(); instr_valid = 1'b0; flags_we = 1'b0; #1;
      check("coinc_nzcv", {4'd0, nzcv_out}, 8'h08);
      check_it("coinc", 8'hA8, 1'b0, 1'b1);
      step_slot();
      check("coinc_end", itstate_out, 8'h00);

      // Reset beats IT reload and flag write mid-block.
      load_flags(4'b1111);
      start_it(4'h0, 4'b0110);
      step_slot();
      check("pre_rst", itstate_out, 8'h0C);
      rst = 1'b1; it_start = 1'b1; it_firstcond = 4'h2; it_mask = 4'h8;
      flags_we = 1'b1; flags_in = alu_flags_t'(4'b0110); instr_valid = 1'b1;
      tick();
      rst = 1'b0; it_start = 1'b0; flags_we = 1'b0; instr_valid = 1'b0; #1;
      check("mid_rst_it",   itstate_out, 8'h00);
      check("mid_rst_nzcv", {4'd0, nzcv_out}, 8'h00);
      check("mid_rst_in",   {7'd0, in_it_block}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
